// File: rtl/vram_pkg.sv
// Shared types and constants for the 160x100 RGB332 video RAM arbiter.
// Address decode helper lives here so every block agrees on the valid range.
package vram_pkg;

    localparam int VRAM_W         = 160;
    localparam int VRAM_H         = 100;
    localparam int VRAM_WORDS     = VRAM_W * VRAM_H;
    localparam int ADDR_W         = 14;
    localparam int DATA_W         = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(VRAM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_ISSUE = 2'd2,
        ACK      = 2'd3
    } cpu_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return (a <= ADDR_LAST);
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of the video, CPU and VRAM-macro signals around the arbiter.
// slave = the arbiter's view, master = the surrounding environment.
interface vram_arbiter_if
    import vram_pkg::*;
();

    logic              vid_rd;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_valid;
    logic [DATA_W-1:0] vid_data;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  vid_rd, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        output vid_valid, vid_data, cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output vid_rd, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        input  vid_valid, vid_data, cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata
    );

endinterface

// File: rtl/vram_wr_fifo.sv
// Posted-write FIFO for CPU writes; show-ahead head entry, wrap-bit pointers.
// Push while full and pop while empty are ignored.
module vram_wr_fifo
    import vram_pkg::*;
#(
    parameter  int DEPTH = FIFO_DEPTH_DEF,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int PTR_W = IDX_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  wr_entry_t        wdata,
    output wr_entry_t        rdata,
    output logic             full,
    output logic             empty,
    output logic [PTR_W-1:0] level
);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    wr_entry_t        mem_q [DEPTH];
    wr_entry_t        mem_d [DEPTH];
    logic             full_s, empty_s, push_ok_s, pop_ok_s;

    // Status decode: equal index with differing wrap bit means full.
    always_comb begin
        empty_s   = (wptr_q == rptr_q);
        full_s    = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) &&
                    (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]);
        push_ok_s = push && !full_s;
        pop_ok_s  = pop && !empty_s;
    end

    // Next-state for pointers and storage.
    always_comb begin
        mem_d = mem_q;
        if (push_ok_s) begin
            mem_d[wptr_q[IDX_W-1:0]] = wdata;
            wptr_d                   = wptr_q + PTR_W'(1'b1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_ok_s) begin
            rptr_d = rptr_q + PTR_W'(1'b1);
        end else begin
            rptr_d = rptr_q;
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end

    assign rdata = mem_q[rptr_q[IDX_W-1:0]];
    assign full  = full_s;
    assign empty = empty_s;
    assign level = wptr_q - rptr_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: fixed-latency video reads win every slot, posted
// CPU writes drain through a FIFO, CPU reads wait for the FIFO to empty.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic           pclk,
    input  logic           reset_n,
    vram_arbiter_if.slave  bus
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    cpu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_oor_q, rd_oor_d;
    logic              ack_rd_q, ack_rd_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              vid_p1_q, vid_p1_d;
    logic              vid_p1_oor_q, vid_p1_oor_d;
    logic              vid_valid_q, vid_valid_d;
    logic              vid_oor_q, vid_oor_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    wr_entry_t         push_entry_s, head_s;
    logic              fifo_full_s, fifo_empty_s, fifo_push_s, fifo_pop_s;
    logic [LVL_W-1:0]  fifo_level_s;
    logic              rd_go_s;
    logic [DATA_W-1:0] vid_data_s, rd_data_s, cpu_rdata_s;

    assign push_entry_s = '{addr: bus.cpu_addr, data: bus.cpu_wdata};

    vram_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk   (pclk),
        .rst_n (reset_n),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .wdata (push_entry_s),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level_s)
    );

    // Slot requests; a full FIFO refuses a push even when a pop happens.
    always_comb begin
        fifo_push_s = (state_q == IDLE) && bus.cpu_req && bus.cpu_we && !fifo_full_s;
        fifo_pop_s  = !fifo_empty_s && !bus.vid_rd;
        rd_go_s     = (state_q == RD_WAIT) && (fifo_level_s == '0) && !bus.vid_rd;
    end

    // VRAM slot mux: video, then FIFO drain, then CPU read.
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        if (bus.vid_rd) begin
            ram_addr_d = addr_in_range(bus.vid_addr) ? bus.vid_addr : '0;
        end else if (fifo_pop_s) begin
            ram_addr_d  = addr_in_range(head_s.addr) ? head_s.addr : '0;
            ram_we_d    = addr_in_range(head_s.addr);
            ram_wdata_d = head_s.data;
        end else if (rd_go_s) begin
            ram_addr_d = addr_in_range(rd_addr_q) ? rd_addr_q : '0;
        end else begin
            ram_addr_d = ram_addr_q;
        end
    end

    // Two-stage video tag pipeline lined up with the RAM read latency.
    always_comb begin
        vid_p1_d     = bus.vid_rd;
        vid_p1_oor_d = bus.vid_rd && !addr_in_range(bus.vid_addr);
        vid_valid_d  = vid_p1_q;
        vid_oor_d    = vid_p1_oor_q;
    end

    // Read data arrives straight from the macro in the ack / valid cycle.
    always_comb begin
        if (vid_valid_q && !vid_oor_q) begin
            vid_data_s = bus.ram_rdata;
        end else begin
            vid_data_s = '0;
        end
        if (ack_rd_q && !rd_oor_q) begin
            rd_data_s = bus.ram_rdata;
        end else begin
            rd_data_s = '0;
        end
        if (cpu_ack_q && ack_rd_q) begin
            cpu_rdata_s = rd_data_s;
        end else begin
            cpu_rdata_s = cpu_rdata_q;
        end
    end

    // CPU request FSM next-state.
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        rd_oor_d    = rd_oor_q;
        ack_rd_d    = 1'b0;
        cpu_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req && bus.cpu_we) begin
                    if (!fifo_full_s) begin
                        state_d   = ACK;
                        cpu_ack_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bus.cpu_req) begin
                    rd_addr_d = bus.cpu_addr;
                    state_d   = RD_WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                if (rd_go_s) begin
                    rd_oor_d = !addr_in_range(rd_addr_q);
                    state_d  = RD_ISSUE;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            RD_ISSUE: begin
                state_d   = ACK;
                cpu_ack_d = 1'b1;
                ack_rd_d  = 1'b1;
            end
            ACK: begin
                state_d = IDLE;
                if (ack_rd_q) begin
                    cpu_rdata_d = rd_data_s;
                end else begin
                    cpu_rdata_d = cpu_rdata_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All arbiter state; reset also drops any in-flight ack or video fetch.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rd_addr_q    <= '0;
            rd_oor_q     <= 1'b0;
            ack_rd_q     <= 1'b0;
            cpu_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            vid_p1_q     <= 1'b0;
            vid_p1_oor_q <= 1'b0;
            vid_valid_q  <= 1'b0;
            vid_oor_q    <= 1'b0;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            rd_oor_q     <= rd_oor_d;
            ack_rd_q     <= ack_rd_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            vid_p1_q     <= vid_p1_d;
            vid_p1_oor_q <= vid_p1_oor_d;
            vid_valid_q  <= vid_valid_d;
            vid_oor_q    <= vid_oor_d;
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
            ram_wdata_q  <= ram_wdata_d;
        end
    end

    assign bus.vid_valid = vid_valid_q;
    assign bus.vid_data  = vid_data_s;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_rdata = cpu_rdata_s;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_wdata = ram_wdata_q;

endmodule
